// File: rtl/daq_mode_switcher.sv
// Routes one of NUM_DAQ acquisition engines onto the shared ASIC control pins.
// A source change drains the active engine, then holds the pins safe for a guard interval.
module daq_mode_switcher #(
    parameter int NUM_DAQ       = 2,
    parameter int SEL_W         = $clog2(NUM_DAQ),
    parameter int GUARD_CYCLES  = 16,
    parameter int DRAIN_TIMEOUT = 1024
) (
    input  logic                   Clk,
    input  logic                   reset,
    input  logic [SEL_W-1:0]       DaqSelect,
    input  logic [4*NUM_DAQ-1:0]   Daq_PWR_ON,
    input  logic [NUM_DAQ-1:0]     Daq_RESET_B,
    input  logic [NUM_DAQ-1:0]     Daq_START_ACQ,
    input  logic [NUM_DAQ-1:0]     Daq_Busy,
    input  logic                   UsbAcqStart,
    output logic                   PWR_ON_A,
    output logic                   PWR_ON_D,
    output logic                   PWR_ON_ADC,
    output logic                   PWR_ON_DAC,
    output logic                   RESET_B,
    output logic                   START_ACQ,
    output logic [NUM_DAQ-1:0]     AcqStart,
    output logic [SEL_W-1:0]       ActiveDaq,
    output logic                   Switching,
    output logic                   SelectError,
    output logic                   DrainTimeout
);

    localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam int DW = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
    localparam logic [GW-1:0]    LP_GUARD_LAST = GW'(GUARD_CYCLES - 1);
    localparam logic [DW-1:0]    LP_DRAIN_LAST = DW'(DRAIN_TIMEOUT - 1);
    localparam logic [SEL_W:0]   LP_NUM        = (SEL_W + 1)'(NUM_DAQ);

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_GUARD} state_t;

    state_t             r_state, w_state_next;
    logic [SEL_W-1:0]   r_target, r_active, w_active_next;
    logic [GW-1:0]      r_guard_cnt, w_guard_cnt_next;
    logic [DW-1:0]      r_drain_cnt, w_drain_cnt_next;
    logic               w_drain_to, w_busy, w_sel_ok, w_usb_ok;
    logic [3:0]         w_pwr [NUM_DAQ];
    logic [NUM_DAQ-1:0] w_acq_hot;

    logic [3:0]         r_pwr;
    logic               r_reset_b, r_start_acq, r_switching, r_sel_err, r_drain_to;
    logic [NUM_DAQ-1:0] r_acq_start;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DAQ; gi++) begin : g_src
            assign w_pwr[gi]     = Daq_PWR_ON[4*gi +: 4];
            assign w_acq_hot[gi] = w_usb_ok && (r_active == SEL_W'(gi));
        end
    endgenerate

    assign w_busy   = Daq_Busy[r_active];
    assign w_sel_ok = ({1'b0, DaqSelect} < LP_NUM);
    // A start only passes when this cycle and the next are both RUN, so none leaks into DRAIN.
    assign w_usb_ok = UsbAcqStart && (r_state == ST_RUN) && (w_state_next == ST_RUN);

    always_comb begin
        w_state_next     = r_state;
        w_active_next    = r_active;
        w_guard_cnt_next = r_guard_cnt;
        w_drain_cnt_next = r_drain_cnt;
        w_drain_to       = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (r_target != r_active) begin
                    w_state_next     = ST_DRAIN;
                    w_drain_cnt_next = '0;
                end
            end
            ST_DRAIN: begin
                if (!w_busy || (r_drain_cnt == LP_DRAIN_LAST)) begin
                    w_drain_to       = w_busy;
                    w_active_next    = r_target;
                    w_guard_cnt_next = LP_GUARD_LAST;
                    w_state_next     = ST_GUARD;
                end else begin
                    w_drain_cnt_next = r_drain_cnt + 1'b1;
                end
            end
            ST_GUARD: begin
                // A retarget while guarding restarts the whole interval on the new source.
                if (r_target != r_active) begin
                    w_active_next    = r_target;
                    w_guard_cnt_next = LP_GUARD_LAST;
                end else if (r_guard_cnt == '0) begin
                    w_state_next     = ST_RUN;
                end else begin
                    w_guard_cnt_next = r_guard_cnt - 1'b1;
                end
            end
            default: begin
                w_state_next     = ST_GUARD;
                w_guard_cnt_next = LP_GUARD_LAST;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_GUARD;
            r_target    <= '0;
            r_active    <= '0;
            r_guard_cnt <= LP_GUARD_LAST;
            r_drain_cnt <= '0;
        end else begin
            r_state     <= w_state_next;
            r_active    <= w_active_next;
            r_guard_cnt <= w_guard_cnt_next;
            r_drain_cnt <= w_drain_cnt_next;
            if (w_sel_ok) begin
                r_target <= DaqSelect;
            end
        end
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_pwr       <= '0;
            r_reset_b   <= 1'b0;
            r_start_acq <= 1'b0;
            r_acq_start <= '0;
            r_switching <= 1'b1;
            r_sel_err   <= 1'b0;
            r_drain_to  <= 1'b0;
        end else begin
            r_sel_err   <= !w_sel_ok;
            r_drain_to  <= w_drain_to;
            r_switching <= (w_state_next != ST_RUN);
            r_acq_start <= w_acq_hot;
            if (w_state_next == ST_GUARD) begin
                r_pwr       <= '0;
                r_reset_b   <= 1'b0;
                r_start_acq <= 1'b0;
            end else begin
                r_pwr       <= w_pwr[r_active];
                r_reset_b   <= Daq_RESET_B[r_active];
                r_start_acq <= Daq_START_ACQ[r_active];
            end
        end
    end

    assign PWR_ON_A     = r_pwr[0];
    assign PWR_ON_D     = r_pwr[1];
    assign PWR_ON_ADC   = r_pwr[2];
    assign PWR_ON_DAC   = r_pwr[3];
    assign RESET_B      = r_reset_b;
    assign START_ACQ    = r_start_acq;
    assign AcqStart     = r_acq_start;
    assign ActiveDaq    = r_active;
    assign Switching    = r_switching;
    assign SelectError  = r_sel_err;
    assign DrainTimeout = r_drain_to;

endmodule
